// File: rtl/muldiv_unit_if.sv
// Request/response bundle between the core and the RV32M multiply/divide unit.
// The core drives the request side (master); the unit drives the result side (slave).
interface muldiv_unit_if #(
   parameter int unsigned XLEN = 32
);
   logic            START;
   logic [2:0]      OP;
   logic [XLEN-1:0] A;
   logic [XLEN-1:0] B;
   logic [4:0]      RD_IN;
   logic            BUSY;
   logic            DONE;
   logic [XLEN-1:0] RESULT;
   logic [4:0]      RD_OUT;
   logic            WR;

   modport master (
      output START, OP, A, B, RD_IN,
      input  BUSY, DONE, RESULT, RD_OUT, WR
   );

   modport slave (
      input  START, OP, A, B, RD_IN,
      output BUSY, DONE, RESULT, RD_OUT, WR
   );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: shift-add multiply, restoring divide.
// Define MULDIV_MUL_EARLY_EN to let multiplies leave CALC once the multiplier is exhausted.
module muldiv_unit #(
   parameter int unsigned XLEN  = 32,
   parameter int unsigned CNT_W = 6
) (
   input  logic CLK,
   input  logic RST_N,
   muldiv_unit_if.slave bus
);

   typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

   state_t            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              fix_ph_q, fix_ph_d;
   logic [2:0]        op_q, op_d;
   logic [4:0]        rd_q, rd_d;
   logic [XLEN-1:0]   mpl_q, mpl_d;     // multiplier, or dividend shifting into quotient
   logic [2*XLEN-1:0] mcd_q, mcd_d;     // multiplicand, or divisor in low word
   logic [2*XLEN-1:0] acc_q, acc_d;     // product, or partial remainder in low bits
   logic              neg_lo_q, neg_lo_d;
   logic              neg_rem_q, neg_rem_d;
   logic [XLEN-1:0]   result_q, result_d;

   logic              in_div, is_div, signed_a, signed_b, sa, sb;
   logic [XLEN-1:0]   abs_a, abs_b;
   logic [XLEN:0]     rem_sh, diff;

   assign in_div   = bus.OP[2];
   assign is_div   = op_q[2];
   assign signed_a = (bus.OP == 3'd1) || (bus.OP == 3'd2) || (bus.OP == 3'd4) || (bus.OP == 3'd6);
   assign signed_b = (bus.OP == 3'd1) || (bus.OP == 3'd4) || (bus.OP == 3'd6);
   assign sa       = signed_a & bus.A[XLEN-1];
   assign sb       = signed_b & bus.B[XLEN-1];
   assign abs_a    = sa ? (XLEN'(0) - bus.A) : bus.A;
   assign abs_b    = sb ? (XLEN'(0) - bus.B) : bus.B;
   assign rem_sh   = {acc_q[XLEN-1:0], mpl_q[XLEN-1]};
   assign diff     = rem_sh - {1'b0, mcd_q[XLEN-1:0]};

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      fix_ph_d  = fix_ph_q;
      op_d      = op_q;
      rd_d      = rd_q;
      mpl_d     = mpl_q;
      mcd_d     = mcd_q;
      acc_d     = acc_q;
      neg_lo_d  = neg_lo_q;
      neg_rem_d = neg_rem_q;
      result_d  = result_q;

      unique case (state_q)
         S_IDLE: begin
            if (bus.START) begin
               op_d      = bus.OP;
               rd_d      = bus.RD_IN;
               cnt_d     = '0;
               fix_ph_d  = 1'b0;
               acc_d     = '0;
               neg_lo_d  = sa ^ sb;
               neg_rem_d = sa;
               state_d   = S_CALC;
               if (in_div) begin
                  mpl_d = abs_a;
                  mcd_d = {{XLEN{1'b0}}, abs_b};
               end else begin
                  mpl_d = abs_b;
                  mcd_d = {{XLEN{1'b0}}, abs_a};
               end
               // Special cases bypass CALC with the final, already-signed values
               if (in_div && (bus.B == '0)) begin
                  mpl_d     = '1;
                  acc_d     = {{XLEN{1'b0}}, bus.A};
                  neg_lo_d  = 1'b0;
                  neg_rem_d = 1'b0;
                  state_d   = S_FIX;
               end else if (in_div && signed_b && (bus.A == {1'b1, {(XLEN-1){1'b0}}})
                            && (bus.B == '1)) begin
                  mpl_d     = {1'b1, {(XLEN-1){1'b0}}};
                  neg_lo_d  = 1'b0;
                  neg_rem_d = 1'b0;
                  state_d   = S_FIX;
               end
`ifdef MULDIV_MUL_EARLY_EN
               else if (!in_div && (abs_b == '0)) begin
                  state_d = S_FIX;
               end
`endif
            end
         end

         S_CALC: begin
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(XLEN-1)) state_d = S_FIX;
            if (is_div) begin
               if (!diff[XLEN]) begin
                  acc_d = {{(XLEN-1){1'b0}}, diff};
                  mpl_d = {mpl_q[XLEN-2:0], 1'b1};
               end else begin
                  acc_d = {{(XLEN-1){1'b0}}, rem_sh};
                  mpl_d = {mpl_q[XLEN-2:0], 1'b0};
               end
            end else begin
               if (mpl_q[0]) acc_d = acc_q + mcd_q;
               mcd_d = mcd_q << 1;
               mpl_d = mpl_q >> 1;
`ifdef MULDIV_MUL_EARLY_EN
               if (mpl_q == '0) begin
                  acc_d   = acc_q;
                  mcd_d   = mcd_q;
                  mpl_d   = mpl_q;
                  state_d = S_FIX;
               end
`endif
            end
         end

         S_FIX: begin
            // Phase 0 negates the magnitudes, phase 1 selects and registers the word
            if (!fix_ph_q) begin
               fix_ph_d = 1'b1;
               if (is_div) begin
                  if (neg_lo_q)  mpl_d = XLEN'(0) - mpl_q;
                  if (neg_rem_q) acc_d = {{XLEN{1'b0}}, XLEN'(0) - acc_q[XLEN-1:0]};
               end else if (neg_lo_q) begin
                  acc_d = (2*XLEN)'(0) - acc_q;
               end
            end else begin
               fix_ph_d = 1'b0;
               state_d  = S_DONE;
               unique case (op_q)
                  3'd0:             result_d = acc_q[XLEN-1:0];
                  3'd1, 3'd2, 3'd3: result_d = acc_q[2*XLEN-1:XLEN];
                  3'd4, 3'd5:       result_d = mpl_q;
                  default:          result_d = acc_q[XLEN-1:0];
               endcase
            end
         end

         S_DONE: state_d = S_IDLE;

         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q   <= S_IDLE;
         cnt_q     <= '0;
         fix_ph_q  <= 1'b0;
         op_q      <= '0;
         rd_q      <= '0;
         mpl_q     <= '0;
         mcd_q     <= '0;
         acc_q     <= '0;
         neg_lo_q  <= 1'b0;
         neg_rem_q <= 1'b0;
         result_q  <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         fix_ph_q  <= fix_ph_d;
         op_q      <= op_d;
         rd_q      <= rd_d;
         mpl_q     <= mpl_d;
         mcd_q     <= mcd_d;
         acc_q     <= acc_d;
         neg_lo_q  <= neg_lo_d;
         neg_rem_q <= neg_rem_d;
         result_q  <= result_d;
      end
   end

   assign bus.BUSY   = (state_q != S_IDLE);
   assign bus.DONE   = (state_q == S_DONE);
   assign bus.WR     = (state_q == S_DONE) && (rd_q != '0);
   assign bus.RESULT = result_q;
   assign bus.RD_OUT = rd_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: results, latency, BUSY/DONE/WR framing, ignored START, mid-op reset.
module tb_muldiv_unit;

   logic CLK = 1'b0;
   logic RST_N = 1'b0;
   int   total = 0;
   int   bad = 0;

   muldiv_unit_if #(.XLEN(32)) bus ();

   muldiv_unit #(.XLEN(32), .CNT_W(6)) dut (
      .CLK   (CLK),
      .RST_N (RST_N),
      .bus   (bus)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] rd, input logic [31:0] exp,
                         input int exp_lat, input bit glitch);
      int n;
      bit busy_ok;
      @(negedge CLK);
      bus.START = 1'b1;
      bus.OP    = op;
      bus.A     = a;
      bus.B     = b;
      bus.RD_IN = rd;
      @(posedge CLK);
      @(negedge CLK);
      bus.START = 1'b0;
      bus.A     = $urandom;
      bus.B     = $urandom;
      n = 0;
      busy_ok = 1'b1;
      while (n < 60) begin
         if (bus.DONE) break;
         if (!bus.BUSY) busy_ok = 1'b0;
         if (glitch && n == 9) begin
            bus.START = 1'b1;
            bus.OP    = 3'd0;
            bus.A     = 32'd3;
            bus.B     = 32'd3;
            bus.RD_IN = 5'd0;
         end else begin
            bus.START = 1'b0;
         end
         @(negedge CLK);
         n++;
      end
      chk({tag, " latency"}, 32'(n), 32'(exp_lat));
      chk({tag, " busy_during"}, 32'(busy_ok), 32'd1);
      chk({tag, " result"}, bus.RESULT, exp);
      chk({tag, " rd_out"}, 32'(bus.RD_OUT), 32'(rd));
      chk({tag, " wr"}, 32'(bus.WR), 32'(rd != 5'd0));
      chk({tag, " busy_at_done"}, 32'(bus.BUSY), 32'd1);
      @(negedge CLK);
      chk({tag, " done_clears"}, 32'(bus.DONE), 32'd0);
      chk({tag, " idle_busy"}, 32'(bus.BUSY), 32'd0);
      chk({tag, " result_held"}, bus.RESULT, exp);
   endtask

   initial begin
      #100000;
      $display("FAIL timeout: simulation exceeded time limit");
      $fatal(1, "timeout");
   end

   initial begin
      int seen_done;
      bus.START = 1'b0;
      bus.OP    = '0;
      bus.A     = '0;
      bus.B     = '0;
      bus.RD_IN = '0;
      repeat (3) @(negedge CLK);
      chk("reset busy", 32'(bus.BUSY), 32'd0);
      chk("reset done", 32'(bus.DONE), 32'd0);
      chk("reset wr", 32'(bus.WR), 32'd0);
      chk("reset result", bus.RESULT, 32'd0);
      chk("reset rd_out", 32'(bus.RD_OUT), 32'd0);
      RST_N = 1'b1;

      run_op("mul",    3'd0, 32'd7,        32'hFFFFFFFD, 5'd5,  32'hFFFFFFEB, 34, 1'b0);
      run_op("mulh",   3'd1, 32'h80000000, 32'h80000000, 5'd6,  32'h40000000, 34, 1'b0);
      run_op("mulhu",  3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd7,  32'hFFFFFFFE, 34, 1'b0);
      run_op("mulhsu", 3'd2, 32'hFFFFFFFF, 32'd2,        5'd8,  32'hFFFFFFFF, 34, 1'b0);
      run_op("div",    3'd4, 32'hFFFFFFF9, 32'd2,        5'd9,  32'hFFFFFFFD, 34, 1'b0);
      run_op("rem",    3'd6, 32'hFFFFFFF9, 32'd2,        5'd10, 32'hFFFFFFFF, 34, 1'b0);
      run_op("divu",   3'd5, 32'd100,      32'd7,        5'd11, 32'd14,       34, 1'b0);
      run_op("remu",   3'd7, 32'd100,      32'd7,        5'd12, 32'd2,        34, 1'b0);

      run_op("divu_by0", 3'd5, 32'd100,      32'd0,        5'd13, 32'hFFFFFFFF, 2, 1'b0);
      run_op("remu_by0", 3'd7, 32'd100,      32'd0,        5'd14, 32'd100,      2, 1'b0);
      run_op("div_ovf",  3'd4, 32'h80000000, 32'hFFFFFFFF, 5'd15, 32'h80000000, 2, 1'b0);
      run_op("rem_ovf",  3'd6, 32'h80000000, 32'hFFFFFFFF, 5'd16, 32'd0,        2, 1'b0);

      run_op("div_glitch", 3'd4, 32'hFFFFFFF9, 32'd2, 5'd17, 32'hFFFFFFFD, 34, 1'b1);
      run_op("divu_rd0",   3'd5, 32'd100,      32'd7, 5'd0,  32'd14,       34, 1'b0);
      run_op("mulhu_pre",  3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd4, 32'hFFFFFFFE, 34, 1'b0);

      @(negedge CLK);
      bus.START = 1'b1;
      bus.OP    = 3'd0;
      bus.A     = 32'd5;
      bus.B     = 32'd9;
      bus.RD_IN = 5'd3;
      @(posedge CLK);
      @(negedge CLK);
      bus.START = 1'b0;
      repeat (14) @(posedge CLK);
      @(posedge CLK);
      #1 RST_N = 1'b0;
      #1;
      chk("midreset busy", 32'(bus.BUSY), 32'd0);
      chk("midreset done", 32'(bus.DONE), 32'd0);
      chk("midreset wr", 32'(bus.WR), 32'd0);
      chk("midreset result", bus.RESULT, 32'd0);
      chk("midreset rd_out", 32'(bus.RD_OUT), 32'd0);
      @(posedge CLK);
      @(posedge CLK);
      #1 RST_N = 1'b1;
      seen_done = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge CLK);
         if (bus.DONE || bus.WR || bus.BUSY) seen_done++;
      end
      chk("postreset quiet", 32'(seen_done), 32'd0);

      run_op("mul_after_reset", 3'd0, 32'd3, 32'd4, 5'd7, 32'd12, 34, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
